// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divide/remainder issue controller.
// Holds the FSM state enum, the op encoding and the special-operand result rules.
package div_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SPECIAL = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_MUL     = 3'd4,
      ST_RESP    = 3'd5
   } div_state_e;

   localparam logic        OP_DIV          = 1'b0;
   localparam logic        OP_REM          = 1'b1;
   localparam logic [31:0] INT_MIN         = 32'h8000_0000;
   localparam int          DIV_TIMEOUT_DEF = 255;

   // Operand pairs the divider is never asked about: x/0, INT_MIN/-1, x/INT_MIN.
   function automatic logic is_special(input logic [31:0] rs1, input logic [31:0] rs2);
      return (rs2 == 32'h0) || ((rs1 == INT_MIN) && (rs2 == 32'hFFFF_FFFF)) || (rs2 == INT_MIN);
   endfunction

   function automatic logic [31:0] special_result(input logic op, input logic [31:0] rs1,
                                                  input logic [31:0] rs2);
      logic [31:0] r;
      if (rs2 == 32'h0)
         r = (op == OP_DIV) ? 32'hFFFF_FFFF : rs1;
      else if (rs2 == INT_MIN)
         r = (op == OP_DIV) ? ((rs1 == INT_MIN) ? 32'd1 : 32'd0)
                            : ((rs1 == INT_MIN) ? 32'd0 : rs1);
      else
         r = (op == OP_DIV) ? INT_MIN : 32'd0;
      return r;
   endfunction

endpackage

// File: rtl/div_issue_ctrl_mul.sv
// 32x32 shift-add multiplier keeping the low 32 product bits.
// start loads the operands; done pulses for one cycle once 32 steps have run.
module seq_mul32 (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] p,
   output logic        done
);

   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] p_q;
   logic [4:0]  cnt_q;
   logic        busy_q;
   logic        done_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         p_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (start) begin
         a_q    <= a;
         b_q    <= b;
         p_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else if (busy_q) begin
         if (b_q[0])
            p_q <= p_q + a_q;
         a_q   <= a_q << 1;
         b_q   <= b_q >> 1;
         cnt_q <= cnt_q + 5'd1;
         if (cnt_q == 5'd31) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end else begin
         done_q <= 1'b0;
      end
   end

   assign p    = p_q;
   assign done = done_q;

endmodule

// File: rtl/div_issue_ctrl.sv
// Issues DIV/REM ops to an external divider, resolves special operands locally,
// derives REM as rs1 - q*rs2 and aborts a stalled divider after DIV_TIMEOUT cycles.
module div_issue_ctrl
   import div_pkg::*;
#(
   parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_op_i,
   input  logic [31:0] req_rs1_i,
   input  logic [31:0] req_rs2_i,
   input  logic [4:0]  req_rd_i,
   output logic [31:0] div_a_o,
   output logic [31:0] div_b_o,
   output logic        div_in_valid_o,
   input  logic        div_in_ready_i,
   input  logic [31:0] div_c_i,
   input  logic        div_out_valid_i,
   output logic        div_out_ready_o,
   output logic        wb_valid_o,
   input  logic        wb_ready_i,
   output logic [31:0] wb_data_o,
   output logic [4:0]  wb_rd_o,
   output logic        wb_err_o,
   output logic        busy_o,
   output div_state_e  dbg_state_o
);

   localparam int          TW       = $clog2(DIV_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(DIV_TIMEOUT - 1);

   div_state_e    state_q, state_d;
   logic          op_q;
   logic [31:0]   rs1_q;
   logic [31:0]   rs2_q;
   logic [4:0]    rd_q;
   logic [31:0]   data_q;
   logic          err_q;
   logic [TW-1:0] tmo_q;
   logic          mul_start;
   logic          mul_done;
   logic [31:0]   mul_p;

   // Every handshake transfers on a posedge where valid && ready; valid never
   // depends on ready and the payload holds steady while valid waits for ready.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (req_valid_i)
                        state_d = is_special(req_rs1_i, req_rs2_i) ? ST_SPECIAL : ST_ISSUE;
         ST_SPECIAL: state_d = ST_RESP;
         ST_ISSUE:   if (div_in_ready_i) state_d = ST_WAIT;
         ST_WAIT:    if (div_out_valid_i)
                        state_d = (op_q == OP_REM) ? ST_MUL : ST_RESP;
                     else if (tmo_q == TMO_LAST)
                        state_d = ST_RESP;
         ST_MUL:     if (mul_done) state_d = ST_RESP;
         ST_RESP:    if (wb_ready_i) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_q   <= OP_DIV;
         rs1_q  <= '0;
         rs2_q  <= '0;
         rd_q   <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
         tmo_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (req_valid_i) begin
               op_q   <= req_op_i;
               rs1_q  <= req_rs1_i;
               rs2_q  <= req_rs2_i;
               rd_q   <= req_rd_i;
               err_q  <= 1'b0;
               data_q <= special_result(req_op_i, req_rs1_i, req_rs2_i);
            end
            // ISSUE always precedes WAIT, so clearing here zeroes the count on WAIT entry.
            ST_ISSUE: tmo_q <= '0;
            ST_WAIT: begin
               if (div_out_valid_i) begin
                  data_q <= div_c_i;
               end else if (tmo_q == TMO_LAST) begin
                  data_q <= '0;
                  err_q  <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            ST_MUL: if (mul_done) data_q <= rs1_q - mul_p;
            default: ;
         endcase
      end
   end

   assign mul_start = (state_q == ST_WAIT) && div_out_valid_i && (op_q == OP_REM);

   seq_mul32 u_mul (
      .clock (clock),
      .reset (reset),
      .start (mul_start),
      .a     (div_c_i),
      .b     (rs2_q),
      .p     (mul_p),
      .done  (mul_done)
   );

   assign req_ready_o     = (state_q == ST_IDLE);
   assign busy_o          = (state_q != ST_IDLE);
   assign div_in_valid_o  = (state_q == ST_ISSUE);
   assign div_out_ready_o = (state_q == ST_WAIT);
   assign div_a_o         = rs1_q;
   assign div_b_o         = rs2_q;
   assign wb_valid_o      = (state_q == ST_RESP);
   assign wb_data_o       = wb_valid_o ? data_q : '0;
   assign wb_rd_o         = wb_valid_o ? rd_q : '0;
   assign wb_err_o        = wb_valid_o & err_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: normal DIV/REM, special operands,
// divider timeout with a late result, and reset in the middle of MUL.
module tb_div_issue_ctrl;
   import div_pkg::*;

   localparam int TMO = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_op;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic [4:0]  req_rd;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        div_in_valid;
   logic        div_in_ready;
   logic [31:0] div_c;
   logic        div_out_valid;
   logic        div_out_ready;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_err;
   logic        busy;
   div_state_e  dbg_state;

   int compared   = 0;
   int mismatched = 0;
   int n;

   div_issue_ctrl #(.DIV_TIMEOUT(TMO)) dut (
      .clock           (clock),
      .reset           (reset),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready),
      .req_op_i        (req_op),
      .req_rs1_i       (req_rs1),
      .req_rs2_i       (req_rs2),
      .req_rd_i        (req_rd),
      .div_a_o         (div_a),
      .div_b_o         (div_b),
      .div_in_valid_o  (div_in_valid),
      .div_in_ready_i  (div_in_ready),
      .div_c_i         (div_c),
      .div_out_valid_i (div_out_valid),
      .div_out_ready_o (div_out_ready),
      .wb_valid_o      (wb_valid),
      .wb_ready_i      (wb_ready),
      .wb_data_o       (wb_data),
      .wb_rd_o         (wb_rd),
      .wb_err_o        (wb_err),
      .busy_o          (busy),
      .dbg_state_o     (dbg_state)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic accept(input logic op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] rd);
      req_valid = 1'b1;
      req_op    = op;
      req_rs1   = rs1;
      req_rs2   = rs2;
      req_rd    = rd;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic issue();
      div_in_ready = 1'b1;
      tick();
      div_in_ready = 1'b0;
   endtask

   task automatic result(input logic [31:0] q);
      div_out_valid = 1'b1;
      div_c         = q;
      tick();
      div_out_valid = 1'b0;
   endtask

   task automatic wait_wb(output int cycles, input int limit);
      cycles = 0;
      while (!wb_valid && cycles < limit) begin
         tick();
         cycles++;
      end
   endtask

   task automatic take();
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      check("wb_drop", wb_valid, 1'b0);
      check("idle_ready", req_ready, 1'b1);
   endtask

   task automatic special(input string tag, input logic op, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] exp);
      accept(op, rs1, rs2, 5'd9);
      check({tag, "_early"}, wb_valid, 1'b0);
      check({tag, "_noissue0"}, div_in_valid, 1'b0);
      tick();
      check({tag, "_valid"}, wb_valid, 1'b1);
      check({tag, "_data"}, wb_data, exp);
      check({tag, "_err"}, wb_err, 1'b0);
      check({tag, "_noissue1"}, div_in_valid, 1'b0);
      take();
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_op = OP_DIV; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
      div_in_ready = 1'b0; div_c = '0; div_out_valid = 1'b0; wb_ready = 1'b0;
      #1;
      check("rst_ready", req_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_wb_valid", wb_valid, 1'b0);
      check("rst_in_valid", div_in_valid, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // DIV 100/7, divider stalls one cycle on input and two on output.
      accept(OP_DIV, 32'd100, 32'd7, 5'd3);
      check("div_in_valid", div_in_valid, 1'b1);
      check("div_a", div_a, 32'd100);
      check("div_b", div_b, 32'd7);
      check("div_busy", busy, 1'b1);
      check("div_not_ready", req_ready, 1'b0);
      accept(OP_REM, 32'd55, 32'd66, 5'd7);
      check("div_ignore_req_a", div_a, 32'd100);
      check("div_still_issue", div_in_valid, 1'b1);
      issue();
      check("div_out_ready", div_out_ready, 1'b1);
      check("div_in_drop", div_in_valid, 1'b0);
      tick();
      tick();
      check("div_a_hold", div_a, 32'd100);
      result(32'd14);
      check("div_wb_valid", wb_valid, 1'b1);
      check("div_wb_data", wb_data, 32'd14);
      check("div_wb_rd", wb_rd, 5'd3);
      check("div_wb_err", wb_err, 1'b0);
      tick();
      check("div_wb_hold", wb_data, 32'd14);
      take();

      // REM -100/7 with q=-14 takes 33 MUL cycles.
      accept(OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd12);
      issue();
      result(32'hFFFF_FFF2);
      check("rem_state_mul", dbg_state, ST_MUL);
      wait_wb(n, 100);
      check("rem_mul_cycles", n, 33);
      check("rem_data", wb_data, 32'hFFFF_FFFE);
      check("rem_rd", wb_rd, 5'd12);
      take();

      special("dz_div", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
      special("dz_rem", OP_REM, 32'd5, 32'd0, 32'd5);
      special("ovf_div", OP_DIV, INT_MIN, 32'hFFFF_FFFF, INT_MIN);
      special("ovf_rem", OP_REM, INT_MIN, 32'hFFFF_FFFF, 32'd0);
      special("min_div", OP_DIV, INT_MIN, INT_MIN, 32'd1);
      special("min_rem", OP_REM, 32'd123, INT_MIN, 32'd123);

      // Divider never answers: abort after TMO cycles, late result not consumed.
      accept(OP_DIV, 32'd9, 32'd3, 5'd4);
      issue();
      wait_wb(n, 40);
      check("tmo_cycles", n, TMO);
      check("tmo_data", wb_data, 32'd0);
      check("tmo_err", wb_err, 1'b1);
      div_out_valid = 1'b1;
      #1;
      check("tmo_late_not_ready", div_out_ready, 1'b0);
      div_out_valid = 1'b0;
      take();

      accept(OP_DIV, 32'd9, 32'd3, 5'd4);
      issue();
      result(32'd3);
      check("post_tmo_data", wb_data, 32'd3);
      check("post_tmo_err", wb_err, 1'b0);
      take();

      // Reset in the middle of MUL while writeback is not ready.
      accept(OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd12);
      issue();
      result(32'hFFFF_FFF2);
      for (int i = 0; i < 5; i++) tick();
      check("mr_in_mul", dbg_state, ST_MUL);
      reset = 1'b1;
      #1;
      check("mr_ready", req_ready, 1'b1);
      check("mr_busy", busy, 1'b0);
      check("mr_wb_valid", wb_valid, 1'b0);
      check("mr_div_a", div_a, 32'd0);
      check("mr_div_b", div_b, 32'd0);
      check("mr_out_ready", div_out_ready, 1'b0);
      check("mr_wb_data", wb_data, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      accept(OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd15);
      issue();
      result(32'hFFFF_FFF2);
      wait_wb(n, 100);
      check("mr2_mul_cycles", n, 33);
      check("mr2_data", wb_data, 32'hFFFF_FFFE);
      check("mr2_rd", wb_rd, 5'd15);
      take();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, required finish within 200000 time units");
      $fatal(1, "bench did not terminate");
   end

endmodule
